// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the fifo_level FIFO and its storage.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_AF_LEVEL  = 12;
    localparam int DEF_AE_LEVEL  = 4;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address.
    function automatic int count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with registered occupancy/threshold flags and sticky error flags.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int AF_LEVEL  = DEF_AF_LEVEL,
    parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Write,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 Read,
    output logic [WIDTH-1:0]     ReadData,
    input  logic                 Flush,
    input  logic                 ClearErrors,
    output logic                 Empty,
    output logic                 Full,
    output logic                 AlmostEmpty,
    output logic                 AlmostFull,
    output logic [ADDR_BITS:0]   Count,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CW    = count_width(ADDR_BITS);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("fifo_level: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $error("fifo_level: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [ADDR_BITS-1:0] wptr_q, wptr_d;
    logic [ADDR_BITS-1:0] rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 ae_q, ae_d;
    logic                 af_q, af_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic rd_acc, wr_acc, ram_we;
    logic ovf_set, unf_set;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
        rd_acc = Read && !empty_q;
        wr_acc = Write && (!full_q || rd_acc);

        if (Flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            ovf_set = Write && full_q && !rd_acc;
            unf_set = Read && empty_q;
            if (wr_acc) begin
                wptr_d = wptr_q + ADDR_BITS'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + ADDR_BITS'(1);
            end
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        end

        ovf_d = (ovf_q && !ClearErrors) || ovf_set;
        unf_d = (unf_q && !ClearErrors) || unf_set;

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        ram_we = wr_acc && !Flush && !Reset;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_C == '0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (WriteData),
        .raddr (rptr_q),
        .rdata (ReadData)
    );

    assign Empty       = empty_q;
    assign Full        = full_q;
    assign AlmostEmpty = ae_q;
    assign AlmostFull  = af_q;
    assign Count       = count_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level: a queue-based reference model predicts the post-edge state of every cycle.
module tb_fifo_level;

    localparam int WIDTH     = 8;
    localparam int ADDR_BITS = 2;
    localparam int DEPTH     = 4;
    localparam int AF_LEVEL  = 3;
    localparam int AE_LEVEL  = 1;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Write = 1'b0;
    logic [WIDTH-1:0] WriteData = '0;
    logic             Read = 1'b0;
    logic [WIDTH-1:0] ReadData;
    logic             Flush = 1'b0;
    logic             ClearErrors = 1'b0;
    logic             Empty, Full, AlmostEmpty, AlmostFull;
    logic [ADDR_BITS:0] Count;
    logic             Overflow, Underflow;

    fifo_level #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .AF_LEVEL  (AF_LEVEL),
        .AE_LEVEL  (AE_LEVEL)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Write       (Write),
        .WriteData   (WriteData),
        .Read        (Read),
        .ReadData    (ReadData),
        .Flush       (Flush),
        .ClearErrors (ClearErrors),
        .Empty       (Empty),
        .Full        (Full),
        .AlmostEmpty (AlmostEmpty),
        .AlmostFull  (AlmostFull),
        .Count       (Count),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int  count;
        bit  empty, full, ae, af, ovf, unf;
        bit  has_data;
        int  data;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Advance the reference model by one clock cycle and queue the state it predicts.
    task automatic model_cycle(input bit rst, input bit fl, input bit wr, input bit rd,
                               input bit clr, input int d);
        exp_t e;
        bit was_empty, was_full, rd_ok, wr_ok;
        if (rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == DEPTH);
            rd_ok = rd && !was_empty;
            wr_ok = wr && (!was_full || rd_ok);
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (fl) begin
                model_q.delete();
            end else begin
                if (wr && was_full && !rd_ok) m_ovf = 1'b1;
                if (rd && was_empty) m_unf = 1'b1;
                if (rd_ok) void'(model_q.pop_front());
                if (wr_ok) model_q.push_back(d);
            end
        end
        e.count    = model_q.size();
        e.empty    = (e.count == 0);
        e.full     = (e.count == DEPTH);
        e.af       = (e.count >= AF_LEVEL);
        e.ae       = (e.count <= AE_LEVEL);
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        e.has_data = (e.count != 0);
        e.data     = e.has_data ? model_q[0] : 0;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit fl, input bit wr, input bit rd,
                        input bit clr, input int d);
        Reset       = rst;
        Flush       = fl;
        Write       = wr;
        Read        = rd;
        ClearErrors = clr;
        WriteData   = d[WIDTH-1:0];
        model_cycle(rst, fl, wr, rd, clr, d);
        @(posedge Clock);
        #2;
    endtask

    // Monitor: after each edge, the FIFO presents its new state; pop one prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",       int'(Count),       e.count);
                chk("empty",       int'(Empty),       int'(e.empty));
                chk("full",        int'(Full),        int'(e.full));
                chk("almost_full", int'(AlmostFull),  int'(e.af));
                chk("almost_empty",int'(AlmostEmpty), int'(e.ae));
                chk("overflow",    int'(Overflow),    int'(e.ovf));
                chk("underflow",   int'(Underflow),   int'(e.unf));
                if (e.has_data) chk("read_data", int'(ReadData), e.data);
            end
        end
    end

    initial begin
        int wait_cycles;
        @(posedge Clock);
        #2;

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 0, 0, i);
            if (i == 2) chk("ae_clears_at_2", int'(AlmostEmpty), 0);
            if (i == 3) chk("af_at_3", int'(AlmostFull), 1);
        end
        chk("full_after_4", int'(Full), 1);
        chk("count_after_4", int'(Count), 4);

        step(0, 0, 1, 0, 0, 'h05);
        chk("overflow_drop", int'(Overflow), 1);
        chk("count_after_drop", int'(Count), 4);

        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        chk("empty_after_drain", int'(Empty), 1);

        step(0, 0, 1, 1, 0, 'hAA);
        chk("rw_empty_count", int'(Count), 1);
        chk("rw_empty_underflow", int'(Underflow), 1);
        chk("rw_empty_data", int'(ReadData), 'hAA);
        step(0, 0, 0, 0, 1, 0);
        chk("clear_underflow", int'(Underflow), 0);

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 'hA1 + i);
        step(0, 0, 1, 1, 0, 'hB0);
        chk("rw_full_count", int'(Count), 4);
        chk("rw_full_flag", int'(Full), 1);
        chk("rw_full_no_ovf", int'(Overflow), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 'h10 + i);
            chk("wrap_data", int'(ReadData), 'h10 + i);
            step(0, 0, 0, 1, 0, 0);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 'h60 + i);
        step(0, 1, 1, 0, 0, 'hEE);
        chk("flush_count", int'(Count), 0);
        chk("flush_empty", int'(Empty), 1);
        step(0, 0, 1, 0, 0, 'h33);
        chk("after_flush_data", int'(ReadData), 'h33);

        step(0, 0, 1, 0, 0, 'h34);
        step(1, 0, 1, 1, 0, 'h35);
        chk("reset_count", int'(Count), 0);
        chk("reset_empty", int'(Empty), 1);
        chk("reset_ae", int'(AlmostEmpty), 1);
        chk("reset_af", int'(AlmostFull), 0);

        for (int i = 0; i < 400; i++) begin
            bit rst, fl, wr, rd, clr;
            rst = ($urandom_range(63) == 0);
            fl  = ($urandom_range(31) == 0);
            wr  = ($urandom_range(99) < 55);
            rd  = ($urandom_range(99) < 45);
            clr = !fl && ($urandom_range(15) == 0);
            step(rst, fl, wr, rd, clr, int'($urandom_range(255)));
        end
        step(0, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge Clock);
            wait_cycles++;
        end
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry.
REQ-002 Parameter ADDR_BITS, default 4: address bits; DEPTH = 2**ADDR_BITS entries, all usable.
REQ-003 Parameter AF_LEVEL, default 12: AlmostFull threshold, legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 4: AlmostEmpty threshold, legal range 0..DEPTH-1.
REQ-005 Clock  input  1  rising-edge clock, sole clock domain.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Write  input  1  write request; WriteData is captured on the same edge.
REQ-008 WriteData  input  WIDTH  data to enqueue.
REQ-009 Read  input  1  read request; pops the head entry.
REQ-010 ReadData  output  WIDTH  head entry, show-ahead (valid whenever Empty=0).
REQ-011 Flush  input  1  synchronous discard of all contents.
REQ-012 ClearErrors  input  1  clears the Overflow and Underflow sticky flags.
REQ-013 Empty, Full  output  1 each  registered occupancy flags.
REQ-014 AlmostEmpty, AlmostFull  output  1 each  registered threshold flags.
REQ-015 Count  output  ADDR_BITS+1  registered occupancy, 0..DEPTH.
REQ-016 Overflow, Underflow  output  1 each  sticky error flags.

Function
REQ-017 Accepted write: Write=1 and (Full=0 or accepted read in the same cycle); RAM[wptr] <= WriteData; wptr += 1 mod DEPTH.
REQ-018 Accepted read: Read=1 and Empty=0; rptr += 1 mod DEPTH; ReadData shows the new head in the next cycle.
REQ-019 Read+Write while empty: write accepted, read ignored; Count becomes 1; Underflow is set.
REQ-020 Read+Write while full: both accepted; Count stays DEPTH; Full stays 1; no Overflow.
REQ-021 Read+Write otherwise: both accepted; Count unchanged.
REQ-022 Write while Full=1 without a read: dropped; RAM and pointers unchanged; Overflow <= 1.
REQ-023 Read while Empty=1 (with or without Write): Underflow <= 1; pointers unchanged by the read.
REQ-024 Count <= Count + accepted write - accepted read; never exceeds DEPTH and never wraps.
REQ-025 Flags derived from next Count and registered: Empty = (Count==0), Full = (Count==DEPTH), AlmostFull = (Count>=AF_LEVEL), AlmostEmpty = (Count<=AE_LEVEL).
REQ-026 Latency: Empty falls and ReadData becomes valid one cycle after the first accepted write.
REQ-027 Pointer wrap from DEPTH-1 to 0 is seamless; data order is preserved across any number of wraps.
REQ-028 Flush=1: pointers <= 0 and Count <= 0; flags take their empty values next cycle; Write and Read are ignored that cycle; RAM contents are don't-care; the sticky flags are unaffected.
REQ-029 ClearErrors=1: both sticky flags <= 0, unless a new error occurs in the same cycle, in which case that flag is set (set wins).
REQ-030 Priority: Reset > Flush > normal operation.

Reset
REQ-031 On Reset=1 at a rising edge: pointers=0, Count=0, Empty=1, AlmostEmpty=1, Full=0, AlmostFull=(AF_LEVEL==0 ? 1 : 0), Overflow=0, Underflow=0.
REQ-032 Reset asserted mid-operation discards all contents in one cycle; RAM is not cleared; ReadData is undefined while Empty=1.

Structure
REQ-033 Shared package fifo_pkg holds the default WIDTH, ADDR_BITS, AF_LEVEL and AE_LEVEL constants and the count-width function (ADDR_BITS+1).
REQ-034 Sub-module fifo_ram holds the register array: one synchronous write port and one asynchronous read port, without reset.
REQ-035 Elaboration fails if AF_LEVEL or AE_LEVEL is outside its legal range.

Verification (bench: WIDTH=8, ADDR_BITS=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-036 Reset then write 0x01..0x04 on 4 cycles -> Count 1,2,3,4; AlmostFull at Count=3; Full=1 after the 4th write; AlmostEmpty clears at Count=2.
REQ-037 While full, write 0x05 -> dropped, Overflow=1, Count=4; then 4 reads -> ReadData 0x01,0x02,0x03,0x04, Empty=1.
REQ-038 Read+Write when empty with WriteData 0xAA -> Count=1, Underflow=1, ReadData=0xAA next cycle; ClearErrors -> Underflow=0.
REQ-039 Read+Write when full -> Count stays 4, Full stays 1, output order intact; 10 single-entry write/read cycles -> pointers wrap, data matches 0x10..0x19.
REQ-040 Fill 3 entries, Flush with Write=1 -> Count=0, Empty=1, new data not stored; Reset mid-fill -> all REQ-031 values next cycle.
